// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM state
// encoding, active-low segment patterns {g,f,e,d,c,b,a}, and idle levels.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // All segments dark / all anodes off
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam logic [2:0] LAST_DIGIT = 3'd7;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);
    import disp_pkg::*;

    // Pure lookup; the capturing register lives in the scan controller
    always_comb begin
        seg_n_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_n_o = SEG_0;
            4'h1: seg_n_o = SEG_1;
            4'h2: seg_n_o = SEG_2;
            4'h3: seg_n_o = SEG_3;
            4'h4: seg_n_o = SEG_4;
            4'h5: seg_n_o = SEG_5;
            4'h6: seg_n_o = SEG_6;
            4'h7: seg_n_o = SEG_7;
            4'h8: seg_n_o = SEG_8;
            4'h9: seg_n_o = SEG_9;
            4'hA: seg_n_o = SEG_A;
            4'hB: seg_n_o = SEG_B;
            4'hC: seg_n_o = SEG_C;
            4'hD: seg_n_o = SEG_D;
            4'hE: seg_n_o = SEG_E;
            4'hF: seg_n_o = SEG_F;
            default: seg_n_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit seven-segment scan controller. Each slot is a BLANK gap
// (anodes off, select settling) followed by a SHOW phase. All outputs are
// registered and computed from the next state, so outputs line up with state.
module disp_scan_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] digit_en,
    input  logic [7:0] dp,
    input  logic [3:0] digit_in,
    output logic [2:0] sel,
    output logic [7:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_done
);
    import disp_pkg::*;

    localparam int MAX_CYC = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       an_n_q, an_n_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_done_q, frame_done_d;
    logic [6:0]       dec_seg;
    logic             cnt_zero;

    hex7seg u_hex7seg (
        .hex_i   (digit_in),
        .seg_n_o (dec_seg)
    );

    assign cnt_zero = (cnt_q == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: dropping en always wins, even on a slot boundary
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_BLANK;
                ST_BLANK: if (cnt_zero) state_d = ST_SHOW;
                ST_SHOW:  if (cnt_zero) state_d = ST_BLANK;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next register values derived from the transition being taken
    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        seg_n_d      = seg_n_q;
        dp_n_d       = dp_n_q;
        an_n_d       = AN_OFF;
        frame_done_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                cnt_d   = '0;
                sel_d   = '0;
                seg_n_d = SEG_OFF;
                dp_n_d  = 1'b1;
            end
            ST_BLANK: begin
                if (state_q == ST_BLANK) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = BLANK_LOAD;
                end
                // Leaving SHOW completes a slot: move on to the next digit
                if (state_q == ST_SHOW) begin
                    sel_d        = sel_q + 3'd1;
                    frame_done_d = (sel_q == LAST_DIGIT);
                end
            end
            ST_SHOW: begin
                if (state_q == ST_SHOW) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // sel has been stable through BLANK, so digit_in is settled
                    cnt_d   = SHOW_LOAD;
                    seg_n_d = dec_seg;
                    dp_n_d  = ~dp[sel_q];
                end
                an_n_d[sel_q] = ~digit_en[sel_q];
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= '0;
            an_n_q       <= AN_OFF;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a slot-timing model pushes per-cycle expected
// outputs into a queue; each scenario task pops and compares every cycle.
module tb_disp_scan_ctrl;

    localparam int TD = 4;
    localparam int BC = 2;
    localparam int TD_M = 1;
    localparam int BC_M = 1;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] digit_en = 8'hFF;
    logic [7:0] dp = 8'h00;
    logic [3:0] mux_off = 4'h0;

    logic [3:0] digit_in, digit_in_m;
    logic [2:0] sel, sel_m;
    logic [7:0] an_n, an_n_m;
    logic [6:0] seg_n, seg_n_m;
    logic       dp_n, dp_n_m;
    logic       frame_done, frame_done_m;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Mux model: x_i = mux_off + i
    assign digit_in   = mux_off + {1'b0, sel};
    assign digit_in_m = mux_off + {1'b0, sel_m};

    disp_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digit_en(digit_en), .dp(dp),
        .digit_in(digit_in), .sel(sel), .an_n(an_n), .seg_n(seg_n),
        .dp_n(dp_n), .frame_done(frame_done)
    );

    disp_scan_ctrl #(.TICK_DIV(TD_M), .BLANK_CYC(BC_M)) dut_min (
        .clk(clk), .rst_n(rst_n), .en(en), .digit_en(digit_en), .dp(dp),
        .digit_in(digit_in_m), .sel(sel_m), .an_n(an_n_m), .seg_n(seg_n_m),
        .dp_n(dp_n_m), .frame_done(frame_done_m)
    );

    function automatic logic [6:0] exp_dec(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic obs_t sample(input bit mini);
        if (mini) return {sel_m, an_n_m, seg_n_m, dp_n_m, frame_done_m};
        return {sel, an_n, seg_n, dp_n, frame_done};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("sel=%0d an_n=%h seg_n=%h dp_n=%b fd=%b", o.sel, o.an, o.seg, o.dp, o.fd);
    endfunction

    // Expected outputs for n cycles after en rises in IDLE (edge 0 = first edge seeing en)
    task automatic push_scan(input int ncyc, input int b, input int t,
                             input logic [7:0] de, input logic [7:0] dpm, input logic [3:0] off);
        int   per, s, p, ps;
        obs_t e;
        per = b + t;
        for (int n = 0; n < ncyc; n++) begin
            s  = (n / per) % 8;
            p  = n % per;
            ps = (s + 7) % 8;
            e.sel = 3'(s);
            e.an  = 8'hFF;
            if (p >= b && de[s]) e.an[s] = 1'b0;
            if (p >= b) begin
                e.seg = exp_dec(4'(off + s));
                e.dp  = ~dpm[s];
            end else if (n < per) begin
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e.seg = exp_dec(4'(off + ps));
                e.dp  = ~dpm[ps];
            end
            e.fd = (p == 0 && s == 0 && n > 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int ncyc);
        for (int n = 0; n < ncyc; n++) exp_q.push_back({3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_idle(2);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            o = sample(k == 1);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_vals dut%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        rst_n = 1'b1;
        push_idle(2);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = sample(0);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL idle_hold cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_full_frame();
        obs_t o, e;
        int   nscan = 97;
        digit_en = 8'hFF; dp = 8'h00; mux_off = 4'h0; en = 1'b1;
        push_scan(nscan, BC, TD, digit_en, dp, mux_off);
        push_idle(1);
        for (int i = 0; i < nscan + 1; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL full_frame cyc %0d: got %s want <queue empty>", i, fmt(o));
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL full_frame cyc %0d: got %s want %s", i, fmt(o), fmt(e));
                end
            end
            if (i == nscan - 1) en = 1'b0;
        end
    endtask

    task automatic test_digit_mask();
        obs_t o, e;
        int   nscan = 50;
        digit_en = 8'h0F; dp = 8'h00; mux_off = 4'h0; en = 1'b1;
        push_scan(nscan, BC, TD, digit_en, dp, mux_off);
        push_idle(1);
        for (int i = 0; i < nscan + 1; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL digit_mask cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == nscan - 1) en = 1'b0;
        end
    endtask

    // Also drops en on the very cycle digit 7's slot ends: no advance, no frame_done
    task automatic test_dp_and_end_race();
        obs_t o, e;
        int   nscan = 48;
        digit_en = 8'hFF; dp = 8'h05; mux_off = 4'h0; en = 1'b1;
        push_scan(nscan, BC, TD, digit_en, dp, mux_off);
        push_idle(2);
        for (int i = 0; i < nscan + 2; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL dp_race cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == nscan - 1) en = 1'b0;
        end
        dp = 8'h00;
    endtask

    task automatic test_hex_upper();
        obs_t o, e;
        int   nscan = 49;
        digit_en = 8'hFF; dp = 8'h00; mux_off = 4'h8; en = 1'b1;
        push_scan(nscan, BC, TD, digit_en, dp, mux_off);
        push_idle(1);
        for (int i = 0; i < nscan + 1; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL hex_upper cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == nscan - 1) en = 1'b0;
        end
        mux_off = 4'h0;
    endtask

    task automatic test_en_drop();
        obs_t o, e;
        int   nscan = 22;
        digit_en = 8'hFF; dp = 8'h00; mux_off = 4'h0; en = 1'b1;
        push_scan(nscan, BC, TD, digit_en, dp, mux_off);
        push_idle(3);
        for (int i = 0; i < nscan + 3; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL en_drop cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == nscan - 1) en = 1'b0;
        end
        en = 1'b1;
        push_scan(9, BC, TD, digit_en, dp, mux_off);
        push_idle(1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL en_restart cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 8) en = 1'b0;
        end
    endtask

    task automatic test_reset_mid_blank();
        obs_t o, e;
        int   nscan = 31;
        digit_en = 8'hFF; dp = 8'h00; mux_off = 4'h0; en = 1'b1;
        push_scan(nscan, BC, TD, digit_en, dp, mux_off);
        for (int i = 0; i < nscan; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL pre_reset cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        // Now in the first BLANK cycle of digit 5; reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        push_idle(1);
        o = sample(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL async_reset: got %s want %s", fmt(o), fmt(e));
        end
        en = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        en = 1'b1;
        push_scan(13, BC, TD, digit_en, dp, mux_off);
        push_idle(1);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL post_reset cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 12) en = 1'b0;
        end
    endtask

    task automatic test_min_slot();
        obs_t o, e;
        int   nscan = 33;
        digit_en = 8'hA5; dp = 8'h81; mux_off = 4'h3; en = 1'b1;
        push_scan(nscan, BC_M, TD_M, digit_en, dp, mux_off);
        push_idle(1);
        for (int i = 0; i < nscan + 1; i++) begin
            @(posedge clk); #1;
            o = sample(1);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL min_slot cyc %0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == nscan - 1) en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_digit_mask();
        test_dp_and_end_race();
        test_hex_upper();
        test_en_drop();
        test_reset_mid_blank();
        test_min_slot();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expect: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
